// File: rtl/pdm_pkg.sv
// Shared types and helpers for the stereo PDM transmitter.
// PCM pairs are packed {ch1, ch0}; samples are signed two's complement.
package pdm_pkg;

  localparam int PCM_W = 16;

  typedef struct packed {
    logic [PCM_W-1:0] ch1;
    logic [PCM_W-1:0] ch0;
  } pcm_pair_t;

  function automatic logic [PCM_W-1:0] offset_bin(
    input logic [PCM_W-1:0] x
  );
    return x ^ {1'b1, {(PCM_W-1){1'b0}}};
  endfunction

endpackage

// File: rtl/pdm_tx_sdm.sv
// Single-channel first-order sigma-delta modulator.
// The output bit is the carry of acc + offset-binary(x).
module pdm_tx_sdm
  import pdm_pkg::*;
#(
  parameter int W = PCM_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         step_i,
  input  logic [W-1:0] x_i,
  output logic         bit_o
);

  localparam logic [W-1:0] MSB = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] u;
  logic [W:0]   sum;

  if (W == PCM_W) begin : g_pkg
    assign u = offset_bin(x_i);
  end else begin : g_gen
    assign u = x_i ^ MSB;
  end

  assign sum   = {1'b0, acc_q} + {1'b0, u};
  assign bit_o = sum[W];

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (step_i) begin
      acc_d = sum[W-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/pdm_tx.sv
// Stereo dual-edge PDM transmitter: Avalon-ST sink, pair FIFO,
// pdm_clk divider and two modulators (ch0 on rises, ch1 on falls).
module pdm_tx
  import pdm_pkg::*;
#(
  parameter int DATA_W     = PCM_W,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 8
) (
  input  logic                          ipg_clk,
  input  logic                          ipg_hard_async_reset,
  input  logic                          enable,
  input  logic [DIV_W-1:0]              clk_div,
  input  logic [DIV_W-1:0]              osr,
  input  logic                          snk_valid,
  output logic                          snk_ready,
  input  logic [2*DATA_W-1:0]           snk_data,
  input  logic                          underrun_clr,
  output logic                          pdm_clk,
  output logic                          pdm_data,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [2*DATA_W-1:0] mem [FIFO_DEPTH];

  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic             rdy_q, rdy_d;
  logic [DIV_W-1:0] div_q, div_d, osr_q, osr_d;
  logic [DIV_W-1:0] div_eff, osr_eff;
  logic             pclk_q, pclk_d, pdat_q, pdat_d;
  logic             und_q, und_d;
  logic [DATA_W-1:0] h0_q, h0_d, h1_q, h1_d;

  logic term, rise, fall, load, empty;
  logic push, pop, b0, b1;

  assign div_eff = (clk_div == '0) ? DIV_W'(1) : clk_div;
  assign osr_eff = (osr == '0) ? DIV_W'(1) : osr;

  assign empty = (lvl_q == '0);
  assign push  = snk_valid & rdy_q;
  // >= rather than == so a shrinking divider never skips its wrap
  assign term  = enable & (div_q >= div_eff - DIV_W'(1));
  assign rise  = term & ~pclk_q;
  assign fall  = term & pclk_q;
  assign load  = rise & (osr_q == '0);
  assign pop   = load & ~empty;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    h0_d  = h0_q;
    h1_d  = h1_q;
    if (push) wr_d = wr_q + AW'(1);
    if (pop) begin
      rd_d = rd_q + AW'(1);
      h0_d = mem[rd_q][DATA_W-1:0];
      h1_d = mem[rd_q][2*DATA_W-1:DATA_W];
    end
    case ({push, pop})
      2'b10:   lvl_d = lvl_q + LW'(1);
      2'b01:   lvl_d = lvl_q - LW'(1);
      default: lvl_d = lvl_q;
    endcase
    rdy_d = (lvl_d < LW'(FIFO_DEPTH));
  end

  always_comb begin
    div_d  = div_q;
    osr_d  = osr_q;
    pclk_d = pclk_q;
    pdat_d = pdat_q;
    if (!enable) begin
      div_d  = '0;
      osr_d  = '0;
      pclk_d = 1'b0;
      pdat_d = 1'b0;
    end else if (term) begin
      div_d  = '0;
      pclk_d = ~pclk_q;
      if (rise) begin
        pdat_d = b0;
        if (osr_q >= osr_eff - DIV_W'(1)) osr_d = '0;
        else osr_d = osr_q + DIV_W'(1);
      end else begin
        pdat_d = b1;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_comb begin
    und_d = und_q;
    if (load & empty) und_d = 1'b1;
    else if (underrun_clr) und_d = 1'b0;
  end

  always_ff @(posedge ipg_clk) begin
    if (push) mem[wr_q] <= snk_data;
  end

  always_ff @(posedge ipg_clk or posedge ipg_hard_async_reset) begin
    if (ipg_hard_async_reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
      rdy_q  <= 1'b1;
      div_q  <= '0;
      osr_q  <= '0;
      pclk_q <= 1'b0;
      pdat_q <= 1'b0;
      und_q  <= 1'b0;
      h0_q   <= '0;
      h1_q   <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      lvl_q  <= lvl_d;
      rdy_q  <= rdy_d;
      div_q  <= div_d;
      osr_q  <= osr_d;
      pclk_q <= pclk_d;
      pdat_q <= pdat_d;
      und_q  <= und_d;
      h0_q   <= h0_d;
      h1_q   <= h1_d;
    end
  end

  // ch0 sees the pair being popped this very rise
  pdm_tx_sdm #(.W(DATA_W)) u_sdm0 (
    .clk_i  (ipg_clk),
    .rst_i  (ipg_hard_async_reset),
    .clr_i  (~enable),
    .step_i (rise),
    .x_i    (h0_d),
    .bit_o  (b0)
  );

  pdm_tx_sdm #(.W(DATA_W)) u_sdm1 (
    .clk_i  (ipg_clk),
    .rst_i  (ipg_hard_async_reset),
    .clr_i  (~enable),
    .step_i (fall),
    .x_i    (h1_q),
    .bit_o  (b1)
  );

  assign snk_ready  = rdy_q;
  assign pdm_clk    = pclk_q;
  assign pdm_data   = pdat_q;
  assign underrun   = und_q;
  assign fifo_level = lvl_q;

endmodule

// File: tb/tb_pdm_tx.sv
// Directed bench for pdm_tx: divider timing, modulator bit patterns,
// underrun, FIFO backpressure and asynchronous reset.
module tb_pdm_tx;
  import pdm_pkg::*;

  logic        ipg_clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  clk_div = 8'd1;
  logic [7:0]  osr = 8'd1;
  logic        snk_valid = 1'b0;
  logic        snk_ready;
  logic [31:0] snk_data = '0;
  logic        underrun_clr = 1'b0;
  logic        pdm_clk, pdm_data, underrun;
  logic [2:0]  fifo_level;

  int errors = 0;
  int checks = 0;

  pdm_tx dut (
    .ipg_clk              (ipg_clk),
    .ipg_hard_async_reset (rst),
    .enable               (enable),
    .clk_div              (clk_div),
    .osr                  (osr),
    .snk_valid            (snk_valid),
    .snk_ready            (snk_ready),
    .snk_data             (snk_data),
    .underrun_clr         (underrun_clr),
    .pdm_clk              (pdm_clk),
    .pdm_data             (pdm_data),
    .underrun             (underrun),
    .fifo_level           (fifo_level)
  );

  always #5 ipg_clk = ~ipg_clk;

  task automatic tick();
    @(posedge ipg_clk);
    #1;
  endtask

  task automatic wait_edge(input logic want);
    logic p;
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      p = pdm_clk;
      tick();
      if (p !== want && pdm_clk === want) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL edge_timeout want=%0b got pdm_clk=%0b", want, pdm_clk);
    end
  endtask

  task automatic push_beat(input pcm_pair_t p);
    logic r;
    bit ok;
    ok = 0;
    snk_valid = 1'b1;
    snk_data  = p;
    for (int i = 0; i < 50; i++) begin
      r = snk_ready;
      tick();
      if (r) begin
        ok = 1;
        break;
      end
    end
    snk_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push_timeout ready=%0b", snk_ready);
    end
  endtask

  task automatic clear_underrun();
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks += 5;
    if (pdm_clk !== 1'b0) begin
      errors++; $display("FAIL rst_pdm_clk got=%b exp=0", pdm_clk);
    end
    if (pdm_data !== 1'b0) begin
      errors++; $display("FAIL rst_pdm_data got=%b exp=0", pdm_data);
    end
    if (underrun !== 1'b0) begin
      errors++; $display("FAIL rst_underrun got=%b exp=0", underrun);
    end
    if (fifo_level !== 3'd0) begin
      errors++; $display("FAIL rst_level got=%0d exp=0", fifo_level);
    end
    if (snk_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready got=%b exp=1", snk_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_divider();
    int n, h, l;
    clk_div = 8'd2;
    osr = 8'd1;
    enable = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (pdm_clk === 1'b1) begin
        n = i;
        break;
      end
    end
    h = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pdm_clk !== 1'b1) break;
      h++;
    end
    l = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pdm_clk !== 1'b0) break;
      l++;
    end
    checks += 3;
    if (n !== 2) begin
      errors++; $display("FAIL div_first_rise got=%0d exp=2", n);
    end
    if (h !== 2) begin
      errors++; $display("FAIL div_high got=%0d exp=2", h);
    end
    if (l !== 2) begin
      errors++; $display("FAIL div_low got=%0d exp=2", l);
    end
    enable = 1'b0;
    tick();
    checks++;
    if (pdm_clk !== 1'b0 || pdm_data !== 1'b0) begin
      errors++;
      $display("FAIL div_disable clk=%b data=%b exp=0,0", pdm_clk, pdm_data);
    end
    clear_underrun();
  endtask

  task automatic test_modulate();
    pcm_pair_t p;
    logic e0;
    p.ch0 = 16'h4000;
    p.ch1 = 16'h8000;
    push_beat(p);
    clk_div = 8'd1;
    osr = 8'd255;
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      e0 = ((k % 4) != 0);
      wait_edge(1'b1);
      checks++;
      if (pdm_data !== e0) begin
        errors++;
        $display("FAIL mod_ch0 step=%0d got=%b exp=%b", k, pdm_data, e0);
      end
      wait_edge(1'b0);
      checks++;
      if (pdm_data !== 1'b0) begin
        errors++;
        $display("FAIL mod_ch1 step=%0d got=%b exp=0", k, pdm_data);
      end
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_full_scale();
    pcm_pair_t p;
    int zeros;
    logic first;
    p.ch0 = 16'h0000;
    p.ch1 = 16'h7FFF;
    push_beat(p);
    clk_div = 8'd1;
    osr = 8'd255;
    enable = 1'b1;
    zeros = 0;
    first = 1'b1;
    for (int k = 0; k < 32; k++) begin
      wait_edge(1'b0);
      if (k == 0) first = pdm_data;
      if (pdm_data === 1'b0) zeros++;
    end
    checks += 2;
    if (first !== 1'b0) begin
      errors++; $display("FAIL fs_first got=%b exp=0", first);
    end
    if (zeros !== 1) begin
      errors++; $display("FAIL fs_zeros got=%0d exp=1", zeros);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_underrun();
    pcm_pair_t p;
    clear_underrun();
    p.ch0 = 16'h1234;
    p.ch1 = 16'h5678;
    push_beat(p);
    clk_div = 8'd1;
    osr = 8'd4;
    enable = 1'b1;
    for (int r = 1; r <= 4; r++) wait_edge(1'b1);
    checks++;
    if (underrun !== 1'b0) begin
      errors++; $display("FAIL und_rise4 got=%b exp=0", underrun);
    end
    wait_edge(1'b1);
    checks += 2;
    if (underrun !== 1'b1) begin
      errors++; $display("FAIL und_rise5 got=%b exp=1", underrun);
    end
    if (fifo_level !== 3'd0) begin
      errors++; $display("FAIL und_level got=%0d exp=0", fifo_level);
    end
    underrun_clr = 1'b1;
    wait_edge(1'b0);
    underrun_clr = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      errors++; $display("FAIL und_clr got=%b exp=0", underrun);
    end
    for (int r = 6; r <= 8; r++) wait_edge(1'b1);
    checks++;
    if (underrun !== 1'b0) begin
      errors++; $display("FAIL und_rise8 got=%b exp=0", underrun);
    end
    wait_edge(1'b1);
    checks++;
    if (underrun !== 1'b1) begin
      errors++; $display("FAIL und_rise9 got=%b exp=1", underrun);
    end
    enable = 1'b0;
    tick();
    clear_underrun();
  endtask

  task automatic test_back_to_back();
    int acc;
    logic r;
    clk_div = 8'd1;
    osr = 8'd1;
    acc = 0;
    snk_valid = 1'b1;
    snk_data = 32'h0001_0000;
    for (int i = 0; i < 8; i++) begin
      r = snk_ready;
      tick();
      if (r) begin
        acc++;
        snk_data = 32'h0001_0000 + 32'(acc);
        if (acc == 4) begin
          checks++;
          if (snk_ready !== 1'b0) begin
            errors++; $display("FAIL bp_ready_after4 got=%b exp=0", snk_ready);
          end
        end
      end
    end
    checks += 3;
    if (acc !== 4) begin
      errors++; $display("FAIL bp_accepted got=%0d exp=4", acc);
    end
    if (fifo_level !== 3'd4) begin
      errors++; $display("FAIL bp_level got=%0d exp=4", fifo_level);
    end
    if (snk_ready !== 1'b0) begin
      errors++; $display("FAIL bp_ready got=%b exp=0", snk_ready);
    end
    enable = 1'b1;
    wait_edge(1'b1);
    checks += 2;
    if (fifo_level !== 3'd3) begin
      errors++; $display("FAIL bp_pop_level got=%0d exp=3", fifo_level);
    end
    if (snk_ready !== 1'b1) begin
      errors++; $display("FAIL bp_pop_ready got=%b exp=1", snk_ready);
    end
    tick();
    snk_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'd4) begin
      errors++; $display("FAIL bp_fifth got=%0d exp=4", fifo_level);
    end
  endtask

  task automatic test_reset_mid();
    logic p;
    clk_div = 8'd0;
    tick();
    for (int i = 0; i < 4; i++) begin
      p = pdm_clk;
      tick();
      checks++;
      if (pdm_clk === p) begin
        errors++; $display("FAIL div0_toggle i=%0d got=%b prev=%b", i, pdm_clk, p);
      end
    end
    rst = 1'b1;
    #2;
    checks += 4;
    if (pdm_clk !== 1'b0) begin
      errors++; $display("FAIL mrst_clk got=%b exp=0", pdm_clk);
    end
    if (pdm_data !== 1'b0) begin
      errors++; $display("FAIL mrst_data got=%b exp=0", pdm_data);
    end
    if (fifo_level !== 3'd0) begin
      errors++; $display("FAIL mrst_level got=%0d exp=0", fifo_level);
    end
    if (snk_ready !== 1'b1) begin
      errors++; $display("FAIL mrst_ready got=%b exp=1", snk_ready);
    end
    tick();
    rst = 1'b0;
    enable = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_divider();
    test_modulate();
    test_full_scale();
    test_underrun();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pdm_tx.md
Name: pdm_tx

Overview:
- Stereo PDM transmitter: converts PCM sample pairs into a single-wire dual-edge PDM bitstream plus the PDM clock.
- Channel 0 is driven after pdm_clk rising edges and channel 1 after falling edges, the standard shared-line mic pairing.
- Serves as a synthesizable microphone model feeding the mic interface in closed-loop tests, and as a PDM DAC path.
- PCM enters through an Avalon-ST sink and is buffered in a small FIFO.

Parameters:
- DATA_W, 16, PCM sample width per channel (signed two's complement).
- FIFO_DEPTH, 4, sample-pair FIFO entries (power of 2, ≥2).
- DIV_W, 8, width of clk_div and osr.

Ports:
- ipg_clk  in  1  system clock
- ipg_hard_async_reset  in  1  asynchronous, active-high reset
- enable  in  1  run control
- clk_div  in  DIV_W  half-period of pdm_clk in ipg_clk cycles; 0 treated as 1
- osr  in  DIV_W  pdm_clk periods per PCM sample; 0 treated as 1
- snk_valid  in  1  Avalon-ST valid
- snk_ready  out  1  Avalon-ST ready
- snk_data  in  2*DATA_W  {ch1, ch0}
- underrun_clr  in  1  clears the underrun flag
- pdm_clk  out  1  PDM clock
- pdm_data  out  1  PDM data
- underrun  out  1  sticky flag: FIFO empty at a sample load
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy

Behaviour:
- Reset values: pdm_clk=0, pdm_data=0, underrun=0, fifo_level=0, snk_ready=1. Accumulators, counters and the held sample are all 0.
- FIFO:
  - A beat is accepted when snk_valid & snk_ready.
  - snk_ready = (fifo_level < FIFO_DEPTH), registered from the level.
  - On a simultaneous push and pop the level is unchanged.
  - FIFO accepts beats regardless of enable.
- Divider:
  - div_cnt counts 0..clk_div_eff-1. At terminal count, pdm_clk toggles and div_cnt returns to 0.
  - pdm_clk period = 2*clk_div_eff cycles.
  - The first rise occurs clk_div_eff cycles after enable is first seen high.
- Rise event (the cycle in which pdm_clk is registered 0→1):
  - If osr_cnt==0, load a sample pair:
    - pop the FIFO if it is non-empty;
    - otherwise keep the previous pair and set underrun=1.
  - osr_cnt = (osr_cnt+1) mod osr_eff.
  - Step the ch0 modulator using the current (possibly just loaded) ch0 value.
  - pdm_data is registered to the ch0 bit in the same edge as pdm_clk.
- Fall event:
  - Step the ch1 modulator.
  - pdm_data is registered to the ch1 bit.
- Modulator (first order, per channel):
  - u = x XOR (1<<(DATA_W-1)), i.e. the offset-binary input.
  - {bit, acc} = acc + u, an (DATA_W+1)-bit sum; the bit is the carry.
  - Over 2^DATA_W steps with constant x, the count of 1s equals u exactly.
- enable low:
  - Synchronously forces pdm_clk=0, pdm_data=0, div_cnt=osr_cnt=0, accumulators=0.
  - The held sample pair and the FIFO contents are retained.
  - Re-enabling restarts from the state defined at reset for these registers.
- underrun:
  - Set takes priority over underrun_clr in the same cycle.
  - Otherwise underrun_clr clears it on the next edge.
- clk_div and osr are sampled continuously. Changing them mid-run takes effect at the next terminal count or wrap, with no glitch shorter than one ipg_clk cycle.
- Reset asserted mid-operation: all registers return immediately to reset values and the FIFO is flushed.

Decomposition:
- Shared package pdm_pkg holds:
  - the DATA_W default constant;
  - typedef pcm_pair_t as a packed struct {ch1, ch0};
  - the function offset_bin(x).
- One sub-module, pdm_tx_sdm: a single-channel first-order modulator with inputs step and x, outputs bit, and a synchronous clear. It is instantiated twice.
- The FIFO is inline.

Test Plan:
- clk_div=2, osr=1, enable rises → pdm_clk first rises 2 cycles later, period 4 cycles, 50% duty.
- Push ch0=16'h4000, ch1=16'h8000, osr=255 → ch0 bits after rises are 0,1,1,1 repeating; ch1 bits after falls are all 0.
- Push ch1=16'h7FFF → ch1 bit sequence is 0,1,1,1,… with a single 0 in the first 65536 steps.
- osr=4, push one pair then none → underrun=1 at the 5th rise event with the pair held. underrun_clr with no new load clears it; it re-asserts at the 9th rise.
- enable=0, push 5 beats with snk_valid held → 4 accepted, fifo_level=4, snk_ready=0 from the cycle after the 4th acceptance. Enable → first rise pops, level=3, snk_ready=1, 5th beat is accepted.
- clk_div=0 → period 2 cycles. Assert reset mid-stream → pdm_clk, pdm_data and fifo_level are 0 and snk_ready=1 during reset.
